// File: rtl/game_state_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_state_ctrl_if
// Signal bundle between the game sequencer and the rest of the game.
//   btn         [2:0]  raw push-buttons (0 = gravity, 1 = start/pause, 2 = end/reset)
//   frame_tick         one-cycle pulse per video frame
//   collision          player/obstacle overlap level from the collision checker
//   gamemode    [1:0]  00 initial, 01 in-game, 10 paused, 11 ended
//   player_y    [8:0]  player vertical position
//   gravity_dir        0 = moving down (+y), 1 = moving up (-y)
//   score       [15:0] frames survived in the current game
//   obstacle_en        obstacle scrolling enable
// master: board/obstacle/renderer side. slave: the sequencer.
// -----------------------------------------------------------------------------
interface game_state_ctrl_if;
    logic [2:0]  btn;
    logic        frame_tick;
    logic        collision;
    logic [1:0]  gamemode;
    logic [8:0]  player_y;
    logic        gravity_dir;
    logic [15:0] score;
    logic        obstacle_en;

    modport master (
        output btn, frame_tick, collision,
        input  gamemode, player_y, gravity_dir, score, obstacle_en
    );

    modport slave (
        input  btn, frame_tick, collision,
        output gamemode, player_y, gravity_dir, score, obstacle_en
    );
endinterface

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Top-level sequencer for the runner game: conditions the three push-buttons,
// runs the game-mode state machine, moves the player once per frame tick and
// counts survived frames as the score.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    game_state_ctrl_if.slave (buttons, frame_tick, collision in;
//          gamemode, player_y, gravity_dir, score, obstacle_en out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_INIT  | waiting for start; position/gravity/score held at start values
// S_PLAY  | game running; player moves and score counts on frame_tick
// S_PAUSE | game frozen; only start/pause or end buttons act
// S_END   | game over; values frozen for display until end/reset button
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int Y_START    = 240,
    parameter int Y_MIN      = 20,
    parameter int Y_MAX      = 460,
    parameter int STEP       = 4,
    parameter int DEB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    game_state_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_END   = 2'b11
    } state_t;

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [8:0] Y_START_P = 9'(Y_START);
    localparam logic [9:0] Y_MIN_W   = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_W   = 10'(Y_MAX);
    localparam logic [9:0] STEP_W    = 10'(STEP);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    accepted;
    logic [2:0]    accepted_d;
    logic [2:0]    press;
    logic [CW-1:0] deb_cnt [3];

    state_t        state_q, state_d;
    logic [8:0]    player_y_q, y_d;
    logic          gravity_dir_q, grav_d;
    logic [15:0]   score_q, score_d;
    logic          obstacle_en_q;

    logic [9:0]    y_raw;
    logic [9:0]    y_moved;
    logic [15:0]   score_sat;

    // Button conditioning. The counter holds the number of differing cycles
    // already seen, so the accepted level flips on the DEB_CYCLES-th
    // consecutive differing cycle. press is registered from the accepted edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            accepted   <= '0;
            accepted_d <= '0;
            press      <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1      <= bus.btn;
            sync2      <= sync1;
            accepted_d <= accepted;
            press      <= accepted & ~accepted_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == accepted[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i]  <= '0;
                    accepted[i] <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Candidate position for this frame, using the current (pre-toggle)
    // direction. Moving up from below STEP is forced to 0 so it clamps to
    // Y_MIN instead of wrapping to a large value.
    always_comb begin
        y_raw   = '0;
        y_moved = '0;
        if (gravity_dir_q) begin
            if ({1'b0, player_y_q} < STEP_W) begin
                y_raw = '0;
            end else begin
                y_raw = {1'b0, player_y_q} - STEP_W;
            end
        end else begin
            y_raw = {1'b0, player_y_q} + STEP_W;
        end
        if (y_raw < Y_MIN_W) begin
            y_moved = Y_MIN_W;
        end else if (y_raw > Y_MAX_W) begin
            y_moved = Y_MAX_W;
        end else begin
            y_moved = y_raw;
        end
    end

    assign score_sat = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

    always_comb begin
        state_d = state_q;
        y_d     = player_y_q;
        grav_d  = gravity_dir_q;
        score_d = score_q;
        case (state_q)
            S_INIT: begin
                y_d     = Y_START_P;
                grav_d  = 1'b0;
                score_d = '0;
                if (press[1]) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (press[2] || bus.collision) begin
                    state_d = S_END;
                end else if (press[1]) begin
                    state_d = S_PAUSE;
                end else begin
                    if (press[0]) begin
                        grav_d = ~gravity_dir_q;
                    end
                    if (bus.frame_tick) begin
                        y_d     = y_moved[8:0];
                        score_d = score_sat;
                    end
                end
            end
            S_PAUSE: begin
                if (press[2]) begin
                    state_d = S_END;
                end else if (press[1]) begin
                    state_d = S_PLAY;
                end
            end
            S_END: begin
                if (press[2]) begin
                    state_d = S_INIT;
                    y_d     = Y_START_P;
                    grav_d  = 1'b0;
                    score_d = '0;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            player_y_q    <= Y_START_P;
            gravity_dir_q <= 1'b0;
            score_q       <= '0;
            obstacle_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            player_y_q    <= y_d;
            gravity_dir_q <= grav_d;
            score_q       <= score_d;
            obstacle_en_q <= (state_d == S_PLAY);
        end
    end

    assign bus.gamemode    = state_q;
    assign bus.player_y    = player_y_q;
    assign bus.gravity_dir = gravity_dir_q;
    assign bus.score       = score_q;
    assign bus.obstacle_en = obstacle_en_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level sequencer for the runner game.
- Conditions the three raw push-buttons and runs the game-mode state machine (initial / in-game / paused / ended).
- Advances the player's vertical position once per frame tick, under a switchable gravity direction.
- Ends the game on collision and counts survived frames as the score.
- Sits between the board buttons, the obstacle generator (via obstacle_en, collision) and the VGA renderer (gamemode, player_y, score).

Parameters:
- Y_START, 240, player y on init/restart (pixels).
- Y_MIN, 20, top clamp for player_y.
- Y_MAX, 460, bottom clamp for player_y.
- STEP, 4, pixels moved per frame_tick while in game.
- DEB_CYCLES, 500000, consecutive stable clk cycles required to accept a button level (use 4 in simulation).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- btn  input  3  raw asynchronous buttons, active high; btn[0] = switch gravity direction, btn[1] = start/pause, btn[2] = end/reset.
- frame_tick  input  1  one-cycle pulse per video frame.
- collision  input  1  level; high when player overlaps an obstacle, from the collision checker.
- gamemode  output  2  00 = initial, 01 = in-game, 10 = paused, 11 = ended.
- player_y  output  9  player y coordinate.
- gravity_dir  output  1  0 = moving down (+y), 1 = moving up (-y).
- score  output  16  frames survived in current game.
- obstacle_en  output  1  high only in in-game; enables obstacle scrolling.

Behaviour:
- One clock domain; clk and rst_n only. rst_n is synchronous, active-low, sampled on posedge clk.
- Reset values:
  - gamemode = 00, player_y = Y_START, gravity_dir = 0, score = 0, obstacle_en = 0.
  - Sync flops, debounce counters and accepted levels all cleared to 0.
- Button conditioning, per bit, independently:
  - Two-flop synchronizer.
  - Debounce counter runs while the synchronized level differs from the accepted level and clears otherwise.
  - When the count reaches DEB_CYCLES, the accepted level updates.
  - press[i] is a one-cycle pulse on an accepted 0->1 transition. Releases generate nothing.
  - A button held through reset release yields one press once debounced.
- Glitches shorter than DEB_CYCLES produce no press.
- State machine, registered; gamemode is the state encoding:
  - INIT (00): hold player_y = Y_START, gravity_dir = 0, score = 0. press[1] -> PLAY. press[0], press[2] and collision are ignored.
  - PLAY (01):
    - press[2] or collision -> END.
    - Else press[1] -> PAUSE.
    - Else press[0] toggles gravity_dir.
    - On frame_tick with no state change: player_y moves by STEP in the gravity direction, and score increments, saturating at 16'hFFFF.
  - PAUSE (10): press[2] -> END; else press[1] -> PLAY. press[0], frame_tick and collision are ignored; player_y and score are frozen.
  - END (11): press[2] -> INIT, which also restores the INIT values on that edge. All other inputs are ignored; player_y, score and gravity_dir are frozen for display.
- Same-cycle priority in PLAY: (press[2] | collision) > press[1] > press[0] > frame_tick movement.
  - On a transition cycle there is no movement, no score increment and no gravity toggle.
  - press[0] and frame_tick in the same cycle: the toggle applies and movement uses the pre-toggle direction.
- Position arithmetic:
  - Computed in 10-bit unsigned, then clamped: result < Y_MIN -> Y_MIN; result > Y_MAX -> Y_MAX.
  - Moving up from below STEP must not wrap; clamp to Y_MIN.
  - Reaching a clamp is not a collision; the player rests there.
- obstacle_en = (next-state == PLAY), registered, so it equals (gamemode == 01) every cycle.
- Latency: raw button edge to the press pulse is DEB_CYCLES + 3 clk. gamemode updates on the clk edge after the press pulse.
- Reset mid-game: returns to INIT values on the next edge regardless of state or pending presses.

Test Plan (DEB_CYCLES = 4, Y_START = 240, STEP = 4, Y_MIN = 20, Y_MAX = 460):
- Reset, hold btn[1] high for 10 clk -> exactly one press. gamemode goes 00 -> 01, obstacle_en = 1. A 3-clk btn[1] glitch -> no change.
- In PLAY, gravity_dir = 0, issue 5 frame_ticks -> player_y = 260, score = 5. Press btn[0], then 5 ticks -> player_y = 240, score = 10.
- In PLAY, gravity up from player_y = 24, 3 ticks -> player_y = 20 and stays 20. Gravity down from 456, 2 ticks -> player_y = 460.
- In PLAY, press btn[1] -> gamemode = 10. 3 ticks -> player_y and score unchanged. Press btn[0] -> gravity_dir unchanged. Press btn[1] -> gamemode = 01.
- In PLAY, assert collision in the same cycle as frame_tick with score = 7 -> gamemode = 11, score stays 7, no move. Press btn[2] -> gamemode = 00, player_y = 240, score = 0, gravity_dir = 0.
- Deassert rst_n for 1 clk while in PAUSE with score = 30 -> next edge: all outputs at reset values.
